sw_array: RTL and testbench
===========================

SW_ARRAY -- requirements
Module: sw_array

Interface
REQ-001 Parameters: none; all sizing comes from package sw_pkg (CACHE_WIDTH=512, LANES=16, LANE_W=32, ADDR_W=16, PIPE_DEPTH=3).
REQ-002 clk  input  1  single clock; all logic on rising edge.
REQ-003 resetb  input  1  synchronous, active-high reset.
REQ-004 sw_bus  interface sw_bus_t  bundle of the signals in REQ-005..REQ-015; direction is from the sw_array side.
REQ-005 sw_bus.start  input  1  level; high requests processing of image lines.
REQ-006 sw_bus.max_weight_buffer_addr  input  16  index of the last filter (weight) line; filters are 0..max.
REQ-007 sw_bus.addr_a  output  16  weight buffer read address (filter index).
REQ-008 sw_bus.addr_b  output  16  image buffer read address (image line index).
REQ-009 sw_bus.data_a  input  512  weight line, valid 1 cycle after addr_a.
REQ-010 sw_bus.data_b  input  512  image line, valid 1 cycle after addr_b.
REQ-011 sw_bus.ready  output  1  high only in IDLE.
REQ-012 sw_bus.valid  output  1  result qualifier, one cycle per result line.
REQ-013 sw_bus.result  output  512  16 lanes of 32-bit signed products.
REQ-014 sw_bus.filters_finished  output  1  1-cycle pulse when the last filter of an image line is issued.
REQ-015 sw_bus.pipeline_full / pipeline_empty  output  1 each  all / none of the 3 pipeline stages hold valid data.

Function
REQ-016 FSM states IDLE, RUN, DRAIN; IDLE->RUN when start=1; RUN->DRAIN at a line boundary with start=0; DRAIN->IDLE when pipeline_empty=1.
REQ-017 In RUN, one (addr_a, addr_b) pair issues per cycle; addr_a steps 0..max_weight_buffer_addr, then returns to 0 and addr_b increments.
REQ-018 addr_b starts at 0 on every IDLE->RUN transition and wraps 0xFFFF->0 without stall.
REQ-019 start dropping mid-line does not abort the line; the line completes and the FSM then enters DRAIN.
REQ-020 max_weight_buffer_addr=0 gives one filter per line, with a filters_finished pulse every RUN cycle.
REQ-021 max_weight_buffer_addr is sampled on IDLE->RUN and held constant for the run.
REQ-022 Pipeline: stage 1 issues addresses; stage 2 captures data_a/data_b; stage 3 registers products; valid/result are asserted 3 cycles after address issue.
REQ-023 Lane i (bits 32i+31:32i) = signed(data_b lane i) × signed(data_a lane i), reduced to 32 bits per REQ-029.
REQ-024 Results appear in issue order, with no gaps while RUN is continuous.
REQ-025 result holds its last value when valid=0.
REQ-026 filters_finished is asserted in the same cycle as the issue with addr_a=max.

Reset
REQ-027 On resetb=1: state=IDLE, addr_a=addr_b=0, all stage-valid bits=0, valid=0, filters_finished=0, result=0, ready=1 on the next cycle, pipeline_empty=1, pipeline_full=0.
REQ-028 Reset mid-operation discards all in-flight data; no valid is asserted afterwards until new issues occur.

Configuration
REQ-029 SW_ARRAY_SATURATE_EN defined: each 64-bit product saturates to [-2^31, 2^31-1]; undefined: the low 32 bits are kept (wrap).

Structure
REQ-030 sw_pkg holds the constants in REQ-001 and the FSM state enum; sw_bus_t is declared in its own interface file.
REQ-031 One sub-module, sw_lane_mul (one 32x32 signed multiply plus optional saturation), is instantiated LANES times.

Verification
REQ-032 Reset then idle -> ready=1, valid=0, pipeline_empty=1.
REQ-033 max=2, start held for 2 lines, all lanes data_a=3, data_b=5 -> 6 valid results, all lanes 15, filters_finished at issue cycles 3 and 6, addr_b 0,0,0,1,1,1.
REQ-034 data_a lanes=-2, data_b lanes=7 -> result lanes 0xFFFFFFF2.
REQ-035 data_a=data_b=0x7FFFFFFF -> 0x7FFFFFFF with SW_ARRAY_SATURATE_EN, 0x00000001 without.
REQ-036 max=3, start dropped after 2 issues -> 4 results total, then DRAIN, then IDLE with ready=1 within 3 cycles of the last issue.
REQ-037 resetb pulsed with 2 results in flight -> no valid afterwards; pipeline_empty=1 the cycle after reset.

Source files
------------

// File: rtl/sw_pkg.sv
// Shared sizing constants, FSM state encoding and payload types for the sw_array block.
package sw_pkg;

    localparam int unsigned CACHE_WIDTH = 512;
    localparam int unsigned LANES       = 16;
    localparam int unsigned LANE_W      = 32;
    localparam int unsigned ADDR_W      = 16;
    localparam int unsigned PIPE_DEPTH  = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    typedef logic [CACHE_WIDTH-1:0] line_t;
    typedef logic [ADDR_W-1:0]      addr_t;

    // One issued (filter, image line) read pair.
    typedef struct packed {
        addr_t addr_a;
        addr_t addr_b;
    } issue_t;

endpackage

// File: rtl/sw_bus_t.sv
// Buffer-side bundle of the sw_array: read addresses/data, handshake and result outputs.
interface sw_bus_t;
    import sw_pkg::*;

    logic  start;
    addr_t max_weight_buffer_addr;
    addr_t addr_a;
    addr_t addr_b;
    line_t data_a;
    line_t data_b;
    logic  ready;
    logic  valid;
    line_t result;
    logic  filters_finished;
    logic  pipeline_full;
    logic  pipeline_empty;

    modport array (
        input  start, max_weight_buffer_addr, data_a, data_b,
        output addr_a, addr_b, ready, valid, result,
               filters_finished, pipeline_full, pipeline_empty
    );

    modport host (
        output start, max_weight_buffer_addr, data_a, data_b,
        input  addr_a, addr_b, ready, valid, result,
               filters_finished, pipeline_full, pipeline_empty
    );
endinterface

// File: rtl/sw_lane_mul.sv
// One 32x32 signed lane multiply; SW_ARRAY_SATURATE_EN clamps the product to 32 bits,
// otherwise the low 32 bits are kept.
module sw_lane_mul
    import sw_pkg::*;
(
    input  logic [LANE_W-1:0] i_a,
    input  logic [LANE_W-1:0] i_b,
    output logic [LANE_W-1:0] o_prod_c
);

`ifdef SW_ARRAY_SATURATE_EN
    localparam int unsigned PROD_W = 2 * LANE_W;

    logic signed [PROD_W-1:0]   w_full;
    logic        [PROD_W-LANE_W:0] w_hi;

    assign w_full = $signed({{LANE_W{i_a[LANE_W-1]}}, i_a}) *
                    $signed({{LANE_W{i_b[LANE_W-1]}}, i_b});
    assign w_hi   = w_full[PROD_W-1:LANE_W-1];

    // Product fits in 32 bits only when the top bits are a pure sign extension.
    always_comb begin
        o_prod_c = w_full[LANE_W-1:0];
        if (!((&w_hi) || !(|w_hi))) begin
            o_prod_c = w_full[PROD_W-1] ? {1'b1, {(LANE_W-1){1'b0}}}
                                        : {1'b0, {(LANE_W-1){1'b1}}};
        end
    end
`else
    assign o_prod_c = i_a * i_b;
`endif

endmodule

// File: rtl/sw_array.sv
// Streams (filter, image line) read pairs and produces 16-lane signed products 3 cycles later.
// Build option: SW_ARRAY_SATURATE_EN selects saturating instead of wrapping lane products.
module sw_array
    import sw_pkg::*;
(
    input  logic   clk,
    input  logic   resetb,
    sw_bus_t.array sw_bus
);

    state_t                r_state;
    state_t                w_state_nxt;
    issue_t                r_issue;
    issue_t                w_issue_nxt;
    addr_t                 r_max;
    addr_t                 w_max_nxt;
    logic                  w_issue_en;
    logic                  w_ff_nxt;
    logic                  w_line_end;
    logic [PIPE_DEPTH-1:0] r_stage_v;
    logic [PIPE_DEPTH-1:0] w_stage_v_nxt;
    line_t                 r_data_a;
    line_t                 r_data_b;
    line_t                 w_prod;
    line_t                 r_result;
    logic                  r_ready;
    logic                  r_valid;
    logic                  r_ff;
    logic                  r_full;
    logic                  r_empty;

    assign w_line_end    = (r_issue.addr_a == r_max);
    assign w_stage_v_nxt = {r_stage_v[PIPE_DEPTH-2:0], w_issue_en};

    always_ff @(posedge clk) begin
        if (resetb) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_issue_en  = 1'b0;
        w_issue_nxt = r_issue;
        w_max_nxt   = r_max;
        case (r_state)
            IDLE: begin
                if (sw_bus.start) begin
                    w_state_nxt = RUN;
                    w_issue_en  = 1'b1;
                    w_issue_nxt = '0;
                    w_max_nxt   = sw_bus.max_weight_buffer_addr;
                end
            end
            RUN: begin
                // A line always completes; start is only consulted at its last filter.
                if (w_line_end) begin
                    if (sw_bus.start) begin
                        w_issue_en         = 1'b1;
                        w_issue_nxt.addr_a = '0;
                        w_issue_nxt.addr_b = r_issue.addr_b + ADDR_W'(1);
                    end else begin
                        w_state_nxt = DRAIN;
                    end
                end else begin
                    w_issue_en         = 1'b1;
                    w_issue_nxt.addr_a = r_issue.addr_a + ADDR_W'(1);
                end
            end
            DRAIN: begin
                // Enter IDLE in the same cycle the last in-flight item leaves the stages.
                if (!(|r_stage_v[PIPE_DEPTH-2:0])) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
        w_ff_nxt = w_issue_en && (w_issue_nxt.addr_a == w_max_nxt);
    end

    always_ff @(posedge clk) begin
        if (resetb) begin
            r_issue   <= '0;
            r_max     <= '0;
            r_stage_v <= '0;
            r_ff      <= 1'b0;
            r_ready   <= 1'b1;
            r_full    <= 1'b0;
            r_empty   <= 1'b1;
            r_valid   <= 1'b0;
            r_result  <= '0;
            r_data_a  <= '0;
            r_data_b  <= '0;
        end else begin
            r_issue   <= w_issue_nxt;
            r_max     <= w_max_nxt;
            r_stage_v <= w_stage_v_nxt;
            r_ff      <= w_ff_nxt;
            r_ready   <= (w_state_nxt == IDLE);
            r_full    <= &w_stage_v_nxt;
            r_empty   <= ~|w_stage_v_nxt;
            r_valid   <= r_stage_v[PIPE_DEPTH-1];
            if (r_stage_v[1]) begin
                r_data_a <= sw_bus.data_a;
                r_data_b <= sw_bus.data_b;
            end
            if (r_stage_v[PIPE_DEPTH-1]) r_result <= w_prod;
        end
    end

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        sw_lane_mul u_mul (
            .i_a      (r_data_b[g*LANE_W +: LANE_W]),
            .i_b      (r_data_a[g*LANE_W +: LANE_W]),
            .o_prod_c (w_prod[g*LANE_W +: LANE_W])
        );
    end

    assign sw_bus.addr_a           = r_issue.addr_a;
    assign sw_bus.addr_b           = r_issue.addr_b;
    assign sw_bus.ready            = r_ready;
    assign sw_bus.valid            = r_valid;
    assign sw_bus.result           = r_result;
    assign sw_bus.filters_finished = r_ff;
    assign sw_bus.pipeline_full    = r_full;
    assign sw_bus.pipeline_empty   = r_empty;

endmodule

// File: tb/tb_sw_array.sv
// Self-checking bench for sw_array: directed and random jobs against a line-level reference model.
module tb_sw_array;

    logic clk = 1'b0;
    logic resetb;
    int   n_assert = 0;
    int   n_fail   = 0;
    int   cyc      = 0;

    logic [511:0] wmem [16];
    logic [511:0] imem [16];
    logic [15:0]  h_a  [8];
    logic [15:0]  h_b  [8];
    logic         h_ff [8];

    sw_bus_t bus ();

    sw_array dut (
        .clk    (clk),
        .resetb (resetb),
        .sw_bus (bus)
    );

    always #5 clk = ~clk;

    // Buffers answer one cycle after the address.
    always @(posedge clk) begin
        bus.data_a <= wmem[bus.addr_a[3:0]];
        bus.data_b <= imem[bus.addr_b[3:0]];
    end

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        h_a[cyc & 7]  = bus.addr_a;
        h_b[cyc & 7]  = bus.addr_b;
        h_ff[cyc & 7] = bus.filters_finished;
    endtask

    function automatic logic [511:0] model(input logic [511:0] w, input logic [511:0] im);
        logic [511:0] r;
        longint p;
        for (int i = 0; i < 16; i++) begin
            p = longint'($signed(im[32*i +: 32])) * longint'($signed(w[32*i +: 32]));
`ifdef SW_ARRAY_SATURATE_EN
            if (p > 64'sd2147483647) p = 64'sd2147483647;
            else if (p < -64'sd2147483648) p = -64'sd2147483648;
`endif
            r[32*i +: 32] = p[31:0];
        end
        return r;
    endfunction

    task automatic fill(input logic [31:0] wv, input logic [31:0] iv, input bit rnd);
        for (int i = 0; i < 16; i++) begin
            if (rnd) begin
                for (int l = 0; l < 16; l++) begin
                    wmem[i][32*l +: 32] = $urandom;
                    imem[i][32*l +: 32] = $urandom;
                end
            end else begin
                wmem[i] = {16{wv}};
                imem[i] = {16{iv}};
            end
        end
    endtask

    // drop_after=0: hold start for 'lines' lines; otherwise drop it after that many issue cycles.
    task automatic run_job(input int m, input int lines, input int drop_after);
        logic [31:0] exp_q[$];
        logic [31:0] e;
        int exp_lines, n_ff, issues, got, ready_cyc, last_valid, prev_valid, total;
        bit started;
        exp_lines  = (drop_after > 0) ? (drop_after + m) / (m + 1) : lines;
        total      = exp_lines * (m + 1);
        for (int b = 0; b < exp_lines; b++)
            for (int f = 0; f <= m; f++) exp_q.push_back({16'(b), 16'(f)});
        n_ff = 0; issues = 0; got = 0; ready_cyc = -1; last_valid = -1; prev_valid = -1;
        started = 1'b0;
        bus.max_weight_buffer_addr = 16'(m);
        bus.start = 1'b1;
        for (int k = 0; k < 400; k++) begin
            tick();
            if (!bus.ready) begin
                if (!started) bus.max_weight_buffer_addr = 16'(m ^ 5);
                started = 1'b1;
                issues++;
            end
            if (drop_after == 0 && issues == 3 && total >= 3)
                chk("pipeline_full", 512'(bus.pipeline_full), 512'(1));
            if (bus.filters_finished) begin
                n_ff++;
                if (drop_after == 0 && n_ff == lines) bus.start = 1'b0;
            end
            if (drop_after > 0 && issues == drop_after) bus.start = 1'b0;
            if (bus.valid) begin
                if (exp_q.size() == 0) begin
                    chk("extra_valid", 512'(1), 512'(0));
                end else begin
                    e = exp_q.pop_front();
                    chk("issue_addr_a", 512'(h_a[(cyc - 3) & 7]), 512'(e[15:0]));
                    chk("issue_addr_b", 512'(h_b[(cyc - 3) & 7]), 512'(e[31:16]));
                    chk("filters_finished", 512'(h_ff[(cyc - 3) & 7]), 512'(e[15:0] == 16'(m)));
                    chk("result", bus.result, model(wmem[e[15:0]], imem[e[31:16]]));
                    if (prev_valid >= 0) chk("valid_gap", 512'(cyc - prev_valid), 512'(1));
                end
                prev_valid = cyc;
                last_valid = cyc;
                got++;
            end
            if (started && bus.ready) begin
                ready_cyc = cyc;
                break;
            end
        end
        chk("job_started", 512'(started), 512'(1));
        chk("job_ready_timeout", 512'(ready_cyc >= 0), 512'(1));
        chk("result_count", 512'(got), 512'(total));
        chk("ff_count", 512'(n_ff), 512'(exp_lines));
        chk("drain_latency", 512'(ready_cyc - (last_valid - 3) <= 3), 512'(1));
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("idle_no_valid", 512'(bus.valid), 512'(0));
        end
        chk("idle_empty", 512'(bus.pipeline_empty), 512'(1));
    endtask

    initial begin
        resetb = 1'b1;
        bus.start = 1'b0;
        bus.max_weight_buffer_addr = '0;
        fill(32'd0, 32'd0, 1'b0);
        tick();
        tick();
        resetb = 1'b0;
        tick();
        tick();
        chk("rst_ready", 512'(bus.ready), 512'(1));
        chk("rst_valid", 512'(bus.valid), 512'(0));
        chk("rst_empty", 512'(bus.pipeline_empty), 512'(1));
        chk("rst_full", 512'(bus.pipeline_full), 512'(0));
        chk("rst_addr_a", 512'(bus.addr_a), 512'(0));
        chk("rst_result", bus.result, 512'(0));

        fill(32'd3, 32'd5, 1'b0);
        run_job(2, 2, 0);
        chk("hold_15", bus.result, {16{32'd15}});

        fill(32'hFFFF_FFFE, 32'd7, 1'b0);
        run_job(1, 1, 0);
        chk("neg_product", bus.result, {16{32'hFFFF_FFF2}});

        fill(32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b0);
        run_job(0, 3, 0);
`ifdef SW_ARRAY_SATURATE_EN
        chk("max_product", bus.result, {16{32'h7FFF_FFFF}});
`else
        chk("max_product", bus.result, {16{32'h0000_0001}});
`endif

        fill(32'd0, 32'd0, 1'b1);
        run_job(3, 0, 2);

        for (int j = 0; j < 4; j++) begin
            fill(32'd0, 32'd0, 1'b1);
            run_job(int'($urandom_range(0, 4)), int'($urandom_range(1, 3)), 0);
        end

        // Reset with two issues in flight.
        bus.max_weight_buffer_addr = 16'd5;
        bus.start = 1'b1;
        tick();
        tick();
        chk("pre_reset_busy", 512'(bus.ready), 512'(0));
        resetb = 1'b1;
        bus.start = 1'b0;
        tick();
        resetb = 1'b0;
        chk("mid_rst_empty", 512'(bus.pipeline_empty), 512'(1));
        chk("mid_rst_ready", 512'(bus.ready), 512'(1));
        chk("mid_rst_valid", 512'(bus.valid), 512'(0));
        chk("mid_rst_ff", 512'(bus.filters_finished), 512'(0));
        chk("mid_rst_addr_b", 512'(bus.addr_b), 512'(0));
        chk("mid_rst_result", bus.result, 512'(0));
        for (int k = 0; k < 6; k++) begin
            tick();
            chk("post_rst_no_valid", 512'(bus.valid), 512'(0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
